// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that drives an 8:1 mux select, with a grant hold timer.
// Optional feature: define MUX_SEL_LOCK_EN to add the lock input, which holds a grant across ack.
module mux_sel_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       ack,
`ifdef MUX_SEL_LOCK_EN
  input  logic       lock,
`endif
  output logic [2:0] sel,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_d;
  logic [2:0] ptr, ptr_d;
  logic [7:0] cnt, cnt_d;
  logic [2:0] sel_d;
  logic       valid_d, timeout_d;
  logic       lock_hold;
  logic [2:0] pick;
  logic       hit;

`ifdef MUX_SEL_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  // First requester at or above ptr, wrapping 7->0.
  always_comb begin
    pick = ptr;
    hit  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!hit && req[ptr + 3'(i)]) begin
        pick = ptr + 3'(i);
        hit  = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state;
    sel_d     = sel;
    valid_d   = valid;
    timeout_d = 1'b0;
    ptr_d     = ptr;
    cnt_d     = cnt;
    unique case (state)
      IDLE: begin
        valid_d = 1'b0;
        if (req != 8'd0) begin
          sel_d   = pick;
          valid_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Priority: ack beats the timer, and the timer beats a dropped request.
        if (ack && lock_hold) begin
          cnt_d = 8'd0;
        end else if (ack) begin
          ptr_d   = sel + 3'd1;
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (cnt == CNT_LAST) begin
          ptr_d     = sel + 3'd1;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (!req[sel]) begin
          ptr_d   = sel + 3'd1;
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= 3'd0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      ptr     <= 3'd0;
      cnt     <= 8'd0;
    end else begin
      state   <= state_d;
      sel     <= sel_d;
      valid   <= valid_d;
      timeout <= timeout_d;
      ptr     <= ptr_d;
      cnt     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed scenarios plus random traffic against a reference model.
// Build with MUX_SEL_LOCK_EN defined to also exercise the lock input.
module tb_mux_sel_arbiter;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       ack;
  logic       lock;
  logic [2:0] sel;
  logic       valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the grant, how long it has been held, where the next search starts.
  logic       m_valid;
  logic [2:0] m_sel;
  logic       m_to;
  int         m_ptr;
  int         m_age;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .ack     (ack),
`ifdef MUX_SEL_LOCK_EN
    .lock    (lock),
`endif
    .sel     (sel),
    .valid   (valid),
    .timeout (timeout)
  );

  task automatic model_reset();
    m_valid = 1'b0;
    m_sel   = 3'd0;
    m_to    = 1'b0;
    m_ptr   = 0;
    m_age   = 0;
  endtask

  task automatic model_edge();
    bit done;
    m_to = 1'b0;
    if (!m_valid) begin
      done = 0;
      for (int i = 0; i < 8; i++) begin
        int idx;
        idx = (m_ptr + i) % 8;
        if (!done && req[idx]) begin
          m_sel   = 3'(idx);
          m_valid = 1'b1;
          m_age   = 0;
          done    = 1;
        end
      end
    end else if (ack && lock) begin
      m_age = 0;
    end else if (ack) begin
      m_ptr   = (int'(m_sel) + 1) % 8;
      m_valid = 1'b0;
    end else if (m_age == TO - 1) begin
      m_ptr   = (int'(m_sel) + 1) % 8;
      m_valid = 1'b0;
      m_to    = 1'b1;
    end else if (!req[m_sel]) begin
      m_ptr   = (int'(m_sel) + 1) % 8;
      m_valid = 1'b0;
    end else begin
      m_age = m_age + 1;
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled on the next falling edge.
  task automatic step(input logic [7:0] r, input logic a, input logic l);
    req  = r;
    ack  = a;
    lock = l;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req   = 8'd0;
    ack   = 1'b0;
    lock  = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sel !== 3'd0 || valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state sel=%0d valid=%0b timeout=%0b expected 0/0/0", sel, valid, timeout);
    end
  endtask

  task automatic test_single();
    int high;
    do_reset();
    high = 0;
    step(8'b0000_0100, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b1 || sel !== 3'd2) begin
      errors++;
      $display("FAIL single_grant sel=%0d valid=%0b expected sel=2 valid=1", sel, valid);
    end
    high += int'(valid);
    step(8'b0000_0100, 1'b0, 1'b0);
    high += int'(valid);
    step(8'b0000_0100, 1'b1, 1'b0);
    checks++;
    if (high !== 2 || valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL single_valid_len cycles=%0d valid=%0b expected cycles=2 valid=0", high, valid);
    end
    step(8'hFF, 1'b0, 1'b0);
    checks++;
    if (sel !== 3'd3 || valid !== 1'b1) begin
      errors++;
      $display("FAIL single_ptr_next sel=%0d valid=%0b expected sel=3 valid=1", sel, valid);
    end
  endtask

  task automatic test_fairness();
    logic [2:0] exp_sel;
    do_reset();
    for (int g = 0; g < 9; g++) begin
      exp_sel = 3'(g % 8);
      step(8'hFF, 1'b0, 1'b0);
      checks++;
      if (valid !== 1'b1 || sel !== exp_sel) begin
        errors++;
        $display("FAIL fair_grant_%0d sel=%0d valid=%0b expected sel=%0d valid=1", g, sel, valid, exp_sel);
      end
      step(8'hFF, 1'b1, 1'b0);
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL fair_gap_%0d valid=%0b expected 0", g, valid);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(8'b0000_0001, 1'b0, 1'b0);
    step(8'b0000_0001, 1'b1, 1'b0);
    step(8'b1000_0001, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b1 || sel !== 3'd7) begin
      errors++;
      $display("FAIL wrap_first sel=%0d valid=%0b expected sel=7 valid=1", sel, valid);
    end
    step(8'b1000_0001, 1'b1, 1'b0);
    step(8'b1000_0001, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b1 || sel !== 3'd0) begin
      errors++;
      $display("FAIL wrap_second sel=%0d valid=%0b expected sel=0 valid=1", sel, valid);
    end
  endtask

  task automatic test_timeout();
    int high;
    do_reset();
    high = 0;
    for (int c = 0; c < TO; c++) begin
      step(8'b0000_1000, 1'b0, 1'b0);
      high += int'(valid);
      checks++;
      if (timeout !== 1'b0 || sel !== 3'd3) begin
        errors++;
        $display("FAIL timeout_hold_%0d sel=%0d timeout=%0b expected sel=3 timeout=0", c, sel, timeout);
      end
    end
    step(8'b0000_1000, 1'b0, 1'b0);
    checks++;
    if (high !== TO || valid !== 1'b0 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire cycles=%0d valid=%0b timeout=%0b expected cycles=%0d valid=0 timeout=1",
               high, valid, timeout, TO);
    end
    step(8'hFF, 1'b0, 1'b0);
    checks++;
    if (timeout !== 1'b0 || valid !== 1'b1 || sel !== 3'd4) begin
      errors++;
      $display("FAIL timeout_after sel=%0d valid=%0b timeout=%0b expected sel=4 valid=1 timeout=0",
               sel, valid, timeout);
    end
  endtask

  task automatic test_ack_vs_timeout();
    do_reset();
    for (int c = 0; c < TO; c++) step(8'b0000_1000, 1'b0, 1'b0);
    step(8'b0000_1000, 1'b1, 1'b0);
    checks++;
    if (valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL ack_wins valid=%0b timeout=%0b expected valid=0 timeout=0", valid, timeout);
    end
    step(8'hFF, 1'b0, 1'b0);
    checks++;
    if (sel !== 3'd4 || valid !== 1'b1) begin
      errors++;
      $display("FAIL ack_wins_ptr sel=%0d valid=%0b expected sel=4 valid=1", sel, valid);
    end
  endtask

  task automatic test_drop();
    do_reset();
    step(8'b0010_0000, 1'b0, 1'b0);
    step(8'b0000_0000, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL drop_revoke valid=%0b timeout=%0b expected valid=0 timeout=0", valid, timeout);
    end
    step(8'hFF, 1'b0, 1'b0);
    checks++;
    if (sel !== 3'd6 || valid !== 1'b1) begin
      errors++;
      $display("FAIL drop_ptr sel=%0d valid=%0b expected sel=6 valid=1", sel, valid);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    step(8'hFF, 1'b0, 1'b0);
    step(8'hFF, 1'b1, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || sel !== 3'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_async sel=%0d valid=%0b timeout=%0b expected 0/0/0", sel, valid, timeout);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(8'hFF, 1'b0, 1'b0);
    checks++;
    if (sel !== 3'd0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_ptr sel=%0d valid=%0b expected sel=0 valid=1", sel, valid);
    end
  endtask

`ifdef MUX_SEL_LOCK_EN
  task automatic test_lock();
    do_reset();
    step(8'b0000_1000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(8'b0000_1000, 1'b1, 1'b1);
      checks++;
      if (valid !== 1'b1 || sel !== 3'd3 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL lock_hold_%0d sel=%0d valid=%0b expected sel=3 valid=1", k, sel, valid);
      end
    end
    step(8'b0000_1000, 1'b1, 1'b0);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL lock_release valid=%0b expected 0", valid);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] r;
    logic       a, l;
    do_reset();
    r = 8'($urandom);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      a = ($urandom_range(0, 3) == 0);
      l = 1'b0;
`ifdef MUX_SEL_LOCK_EN
      l = ($urandom_range(0, 2) == 0);
`endif
      step(r, a, l);
      checks++;
      if (valid !== m_valid || sel !== m_sel || timeout !== m_to) begin
        errors++;
        $display("FAIL random_%0d sel=%0d valid=%0b timeout=%0b expected sel=%0d valid=%0b timeout=%0b",
                 n, sel, valid, timeout, m_sel, m_valid, m_to);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'd0;
    ack   = 1'b0;
    lock  = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_timeout();
    test_ack_vs_timeout();
    test_drop();
    test_reset_mid_grant();
`ifdef MUX_SEL_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum cycles a grant is held without ack (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 8 bits: request per mux data input a..h (bit 0 = a, bit 7 = h).
REQ-005 The block SHALL have port ack, input, 1 bit: the downstream consumer has taken the selected data this cycle.
REQ-006 The block SHALL have port sel, output, 3 bits, registered: drives the 8:1 mux select directly.
REQ-007 The block SHALL have port valid, output, 1 bit, registered: sel holds a live grant.
REQ-008 The block SHALL have port timeout, output, 1 bit, registered: one-cycle pulse when a grant is revoked by timer.
REQ-009 When compiled with MUX_SEL_LOCK_EN, the block SHALL have port lock, input, 1 bit: holds the current grant across ack.

Function
REQ-010 The block SHALL implement a two-state FSM, IDLE and GRANT, plus a 3-bit round-robin pointer ptr and an 8-bit hold counter cnt.
REQ-011 In IDLE with req != 0, the block SHALL select the first set req bit searching upward from ptr with wrap 7->0, load sel, set valid, clear cnt and enter GRANT, with latency 1 cycle from req sampled to valid=1.
REQ-012 In IDLE with req == 0, the block SHALL hold valid=0 and leave sel unchanged.
REQ-013 In GRANT, the block SHALL keep sel stable and increment cnt each cycle.
REQ-014 In GRANT, ack=1 SHALL set ptr=sel+1 (mod 8), clear valid and enter IDLE; the next grant can appear at earliest 2 cycles after the previous grant.
REQ-015 In GRANT, if req[sel] drops with ack=0, the block SHALL revoke: ptr=sel+1, valid=0, enter IDLE, no timeout pulse.
REQ-016 In GRANT, if cnt reaches TIMEOUT-1 with ack=0, the block SHALL revoke as in REQ-015 and assert timeout for exactly one cycle, coincident with valid falling.
REQ-017 When ack and the timeout condition coincide, ack SHALL win and timeout SHALL stay 0.
REQ-018 When ack and the drop of req[sel] coincide, the block SHALL treat it as ack.
REQ-019 In IDLE, the block SHALL ignore ack.
REQ-020 Fairness: with all eight req bits constantly high and ack on every grant, sel SHALL visit 0,1,...,7,0 in order.

Reset
REQ-021 While rst_n=0, regardless of clk: state=IDLE, sel=0, valid=0, timeout=0, ptr=0, cnt=0.
REQ-022 Reset asserted mid-grant SHALL drop valid immediately, with no timeout pulse; after release the first grant SHALL search from ptr=0.

Configuration
REQ-023 The macro MUX_SEL_LOCK_EN SHALL control the lock feature.
REQ-024 With MUX_SEL_LOCK_EN defined, ack=1 and lock=1 in GRANT SHALL keep state GRANT with the same sel, clear cnt and leave ptr unchanged; timeout still applies between acks.
REQ-025 Without MUX_SEL_LOCK_EN defined, the lock port SHALL not exist and behaviour SHALL be exactly as REQ-014.

Verification
REQ-026 The bench SHALL cover: req=8'b0000_0100 from reset, ack one cycle after valid -> sel=2, valid high for 2 cycles, then ptr=3.
REQ-027 The bench SHALL cover: req=8'hFF held, ack on every grant -> sel sequence 0..7,0 with valid pulses every 2 cycles.
REQ-028 The bench SHALL cover: req=8'b1000_0001, ptr=1 -> sel=7 first, then 0 (wrap).
REQ-029 The bench SHALL cover: TIMEOUT=4, req[3] held, no ack -> valid high 4 cycles, then timeout=1 for 1 cycle, valid=0, next grant searches from 4.
REQ-030 The bench SHALL cover: ack and the timeout condition in the same cycle -> timeout stays 0 and ptr advances.
REQ-031 The bench SHALL cover: rst_n pulsed low mid-GRANT -> valid=0 and sel=0 asynchronously; and with MUX_SEL_LOCK_EN defined, lock=1 plus 3 acks -> sel unchanged and valid continuously high.
